rv32is: RTL and testbench
=========================

Name: rv32is

Overview:
- Single-cycle RV32I integer core: fetch, decode, execute, memory access and writeback of one instruction per clk.
- Drives an external synchronous-read instruction memory and a byte-maskable data memory.
- Exposes the full register file, the committed-PC trace and halt/commit status, so a shell can compare architectural state per test case.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- HALT_INSTR, 32'hdead10cc, instruction word that halts the core.

Ports:
- clk  in  1  clock clk.
- reset  in  1  reset reset, synchronous, active-high.
- imemaddr  out  32  byte address of next instruction (next-PC, combinational).
- imemdataout  in  32  instruction word; memory registers it on posedge imemclk.
- imemclk  out  1  instruction memory clock, equals clk.
- dmemaddr  out  32  data byte address (rs1+imm).
- dmemdataout  in  32  load data, already extended by memory per dmemop, combinational.
- dmemdatain  out  32  store data (rs2, unshifted).
- dmemrdclk  out  1  equals clk.
- dmemwrclk  out  1  equals clk; memory writes on posedge.
- dmemop  out  3  000 word, 001 byte, 010 half, 101 byte-unsigned, 110 half-unsigned.
- dmemwe  out  1  store enable.
- dbg_pc  out  32  PC of instruction completed at last edge.
- done  out  1  current instruction == HALT_INSTR.
- wb  out  1  an instruction completed at last edge.
- reg00..reg31  out  32 each  register file contents; reg00 always 0.

Behaviour:
- Instruction fetch:
  - The instruction register is external; at each posedge, the memory latches mem[imemaddr>>2].
  - During reset, imemaddr=RESET_PC, so after reset the current instruction is the one at RESET_PC.
- Reset values:
  - Applied while reset is high at posedge: PC=RESET_PC, wb=0, dbg_pc=0, dmemwe=0.
  - Registers x1..x31 = 0.
  - Reset must be held ≥2 cycles; asserting it mid-program aborts the current instruction with no writes.
- Per cycle (not reset, not done):
  - Decode the current instruction, compute next PC, register result, store.
  - At posedge: PC<=nextPC; rd<=result if rd≠0; data memory written if store.
  - Also at posedge: wb<=1, dbg_pc<=PC.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Immediates are sign-extended per I/S/B/U/J formats; shift amounts use the low 5 bits.
- Arithmetic is 32-bit wraparound.
- Control flow:
  - JAL/JALR write PC+4 to rd.
  - JALR target = (rs1+imm) with bit0 cleared.
  - Taken branch: PC+imm; otherwise PC+4.
  - Misaligned targets are not trapped.
- dmemop mapping from funct3: 000→001, 001→010, 010→000, 100→101, 101→110. Stores use the same mapping.
- dmemwe=1 only for stores, and only when not in reset and not halted.
- Halt:
  - When the instruction == HALT_INSTR, done=1 (combinational).
  - PC, registers and memory hold; imemaddr=PC; wb<=0.
- Unknown opcodes, FENCE and SYSTEM execute as NOP (PC+4, no writes, wb=1).

Optional Feature:
- Macro ILLEGAL_HALT_EN.
- Defined: an unknown opcode behaves like HALT_INSTR (done=1, PC frozen, no writes, wb=0).
- Undefined: unknown opcodes are NOPs as above.

Test Plan:
- Reset 2 cycles; mem[0]=addi x1,x0,5, mem[1]=addi x2,x1,-7 → after edge 1: reg01=5, wb=1, dbg_pc=0. After edge 2: reg02=0xFFFFFFFE, dbg_pc=4.
- lui x3,0x12345; addi x3,x3,0x678; sw x3,0(x0); lb x4,1(x0); lbu x5,3(x0) → reg04=0x00000056, reg05=0x00000012; data word0=0x12345678.
- sh of 0xBEEF at addr 2 over word 0 → word0=0xBEEF5678; lh from addr 2 → 0xFFFFBEEF.
- beq x0,x0,+8 at PC 0x10 → next dbg_pc 0x18. jal x1,-0x18 at 0x18 → reg01=0x1C, PC=0x00. jalr x0,1(x1) → PC=0x1C.
- addi x0,x0,1 → reg00 stays 0. sra of 0x80000000 by 4 → 0xF8000000. sltu 1<0xFFFFFFFF → 1.
- 0xdead10cc at 0x20 → done=1, PC and registers frozen for 10 cycles, wb=0. Reset assertion restarts at RESET_PC with done=0.

Source files
------------

// File: rtl/rv32is.sv
// rv32is: single-cycle RV32I integer core.
// One instruction per clk: fetch, decode, execute, memory access, writeback.
// The instruction register lives in the external memory. It latches
// mem[imemaddr>>2] on every posedge, so imemaddr carries the next PC.
// The data memory returns load data already extended for dmemop, and it
// performs the byte-lane placement of store data itself.
// Optional build macro ILLEGAL_HALT_EN: when defined, an unknown opcode
// halts the core as HALT_INSTR does. When undefined, it executes as a NOP.
module rv32is #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hdead10cc
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemdataout,
    output logic        imemclk,
    output logic [31:0] dmemaddr,
    input  logic [31:0] dmemdataout,
    output logic [31:0] dmemdatain,
    output logic        dmemrdclk,
    output logic        dmemwrclk,
    output logic [2:0]  dmemop,
    output logic        dmemwe,
    output logic [31:0] dbg_pc,
    output logic        done,
    output logic        wb,
    output logic [31:0] reg00,
    output logic [31:0] reg01,
    output logic [31:0] reg02,
    output logic [31:0] reg03,
    output logic [31:0] reg04,
    output logic [31:0] reg05,
    output logic [31:0] reg06,
    output logic [31:0] reg07,
    output logic [31:0] reg08,
    output logic [31:0] reg09,
    output logic [31:0] reg10,
    output logic [31:0] reg11,
    output logic [31:0] reg12,
    output logic [31:0] reg13,
    output logic [31:0] reg14,
    output logic [31:0] reg15,
    output logic [31:0] reg16,
    output logic [31:0] reg17,
    output logic [31:0] reg18,
    output logic [31:0] reg19,
    output logic [31:0] reg20,
    output logic [31:0] reg21,
    output logic [31:0] reg22,
    output logic [31:0] reg23,
    output logic [31:0] reg24,
    output logic [31:0] reg25,
    output logic [31:0] reg26,
    output logic [31:0] reg27,
    output logic [31:0] reg28,
    output logic [31:0] reg29,
    output logic [31:0] reg30,
    output logic [31:0] reg31
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] pc;
    logic [31:0] rf [0:31];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    logic [31:0] alu_b, alu_out;
    logic [4:0]  shamt;

    logic [31:0] next_pc;
    logic [31:0] rd_val;
    logic        rd_we;
    logic        is_store;
    logic        unknown_op;
    logic        halt;
    logic        active;

    assign instr  = imemdataout;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    // Shared ALU for register-register and register-immediate operations
    always_comb begin
        alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
        shamt   = alu_b[4:0];
        alu_out = 32'd0;
        case (funct3)
            3'b000: alu_out = (opcode == OP_REG && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << shamt;
            3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'd0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = instr[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    // Decode: next PC, register writeback value and store request
    always_comb begin
        next_pc    = pc + 32'd4;
        rd_val     = 32'd0;
        rd_we      = 1'b0;
        is_store   = 1'b0;
        unknown_op = 1'b0;
        case (opcode)
            OP_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OP_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc + 32'd4;
                next_pc = (rs1_val + imm_i) & 32'hFFFF_FFFE;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000: if (rs1_val == rs2_val) next_pc = pc + imm_b;
                    3'b001: if (rs1_val != rs2_val) next_pc = pc + imm_b;
                    3'b100: if ($signed(rs1_val) <  $signed(rs2_val)) next_pc = pc + imm_b;
                    3'b101: if ($signed(rs1_val) >= $signed(rs2_val)) next_pc = pc + imm_b;
                    3'b110: if (rs1_val <  rs2_val) next_pc = pc + imm_b;
                    3'b111: if (rs1_val >= rs2_val) next_pc = pc + imm_b;
                    default: next_pc = pc + 32'd4;
                endcase
            end
            OP_LOAD: begin
                rd_we  = 1'b1;
                rd_val = dmemdataout;
            end
            OP_STORE: is_store = 1'b1;
            OP_IMM, OP_REG: begin
                rd_we  = 1'b1;
                rd_val = alu_out;
            end
            OP_FENCE, OP_SYSTEM: rd_we = 1'b0;
            default: unknown_op = 1'b1;
        endcase
    end

    // Width/sign code for the data memory, shared by loads and stores
    always_comb begin
        case (funct3)
            3'b000:  dmemop = 3'b001;
            3'b001:  dmemop = 3'b010;
            3'b100:  dmemop = 3'b101;
            3'b101:  dmemop = 3'b110;
            default: dmemop = 3'b000;
        endcase
    end

`ifdef ILLEGAL_HALT_EN
    assign halt = (instr == HALT_INSTR) || unknown_op;
`else
    assign halt = (instr == HALT_INSTR);
`endif

    assign done   = halt;
    assign active = !reset && !halt;

    // While halted, keep refetching the halt word so the core stays parked
    assign imemaddr   = reset ? RESET_PC : (halt ? pc : next_pc);
    assign imemclk    = clk;
    assign dmemrdclk  = clk;
    assign dmemwrclk  = clk;
    assign dmemaddr   = rs1_val + (is_store ? imm_s : imm_i);
    assign dmemdatain = rs2_val;
    assign dmemwe     = is_store && active;

    // Architectural state update: PC, commit trace and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            wb     <= 1'b0;
            dbg_pc <= 32'd0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (halt) begin
            wb <= 1'b0;
        end else begin
            pc     <= next_pc;
            wb     <= 1'b1;
            dbg_pc <= pc;
            if (rd_we && rd != 5'd0) rf[rd] <= rd_val;
        end
    end

    assign reg00 = 32'd0;
    assign reg01 = rf[1];
    assign reg02 = rf[2];
    assign reg03 = rf[3];
    assign reg04 = rf[4];
    assign reg05 = rf[5];
    assign reg06 = rf[6];
    assign reg07 = rf[7];
    assign reg08 = rf[8];
    assign reg09 = rf[9];
    assign reg10 = rf[10];
    assign reg11 = rf[11];
    assign reg12 = rf[12];
    assign reg13 = rf[13];
    assign reg14 = rf[14];
    assign reg15 = rf[15];
    assign reg16 = rf[16];
    assign reg17 = rf[17];
    assign reg18 = rf[18];
    assign reg19 = rf[19];
    assign reg20 = rf[20];
    assign reg21 = rf[21];
    assign reg22 = rf[22];
    assign reg23 = rf[23];
    assign reg24 = rf[24];
    assign reg25 = rf[25];
    assign reg26 = rf[26];
    assign reg27 = rf[27];
    assign reg28 = rf[28];
    assign reg29 = rf[29];
    assign reg30 = rf[30];
    assign reg31 = rf[31];

endmodule

// File: tb/tb_rv32is.sv
// tb_rv32is: testbench for the rv32is core with behavioural instruction and
// data memories. The expected commit-PC trace of each program is queued as
// the program is loaded and is popped on every wb.
module tb_rv32is;

    localparam logic [31:0] HALT = 32'hdead10cc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imemaddr, imemdataout, dmemaddr, dmemdataout, dmemdatain, dbg_pc;
    logic        imemclk, dmemrdclk, dmemwrclk, dmemwe, done, wb;
    logic [2:0]  dmemop;
    logic [31:0] r [0:31];

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    logic [31:0] imem_q = 32'd0;

    logic [31:0] exp_pc_q [$];
    int n_chk = 0;
    int n_pass = 0;
    int n_commit = 0;

    rv32is dut (
        .clk(clk), .reset(reset),
        .imemaddr(imemaddr), .imemdataout(imemdataout), .imemclk(imemclk),
        .dmemaddr(dmemaddr), .dmemdataout(dmemdataout), .dmemdatain(dmemdatain),
        .dmemrdclk(dmemrdclk), .dmemwrclk(dmemwrclk), .dmemop(dmemop), .dmemwe(dmemwe),
        .dbg_pc(dbg_pc), .done(done), .wb(wb),
        .reg00(r[0]),  .reg01(r[1]),  .reg02(r[2]),  .reg03(r[3]),
        .reg04(r[4]),  .reg05(r[5]),  .reg06(r[6]),  .reg07(r[7]),
        .reg08(r[8]),  .reg09(r[9]),  .reg10(r[10]), .reg11(r[11]),
        .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
        .reg16(r[16]), .reg17(r[17]), .reg18(r[18]), .reg19(r[19]),
        .reg20(r[20]), .reg21(r[21]), .reg22(r[22]), .reg23(r[23]),
        .reg24(r[24]), .reg25(r[25]), .reg26(r[26]), .reg27(r[27]),
        .reg28(r[28]), .reg29(r[29]), .reg30(r[30]), .reg31(r[31])
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    always @(posedge imemclk) imem_q <= imem[imemaddr[7:2]];
    assign imemdataout = imem_q;

    // Data memory: byte-lane writes on posedge, extended combinational reads
    always @(posedge dmemwrclk) begin
        if (dmemwe) begin
            case (dmemop)
                3'b001, 3'b101: dmem[dmemaddr[7:2]][8*dmemaddr[1:0] +: 8] <= dmemdatain[7:0];
                3'b010, 3'b110: dmem[dmemaddr[7:2]][16*dmemaddr[1] +: 16] <= dmemdatain[15:0];
                default:        dmem[dmemaddr[7:2]] <= dmemdatain;
            endcase
        end
    end

    always_comb begin
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = dmem[dmemaddr[7:2]];
        b = w[8*dmemaddr[1:0] +: 8];
        h = w[16*dmemaddr[1] +: 16];
        case (dmemop)
            3'b001:  dmemdataout = {{24{b[7]}}, b};
            3'b101:  dmemdataout = {24'd0, b};
            3'b010:  dmemdataout = {{16{h[15]}}, h};
            3'b110:  dmemdataout = {16'd0, h};
            default: dmemdataout = w;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Commit monitor: every wb pops one expected PC
    always @(negedge clk) begin
        if (!reset && wb) begin
            n_commit++;
            if (exp_pc_q.size() > 0) chk("trace_pc", dbg_pc, exp_pc_q.pop_front());
        end
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imemaddr", imemaddr, 32'h0);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            imem[i] = HALT;
            dmem[i] = 32'd0;
        end

        // Program 1: arithmetic, loads/stores, halt
        imem[0]  = enc_i(5, 0, 3'b000, 1, 7'b0010011);          // addi x1,x0,5
        imem[1]  = enc_i(-7, 1, 3'b000, 2, 7'b0010011);         // addi x2,x1,-7
        imem[2]  = enc_u(20'h12345, 3, 7'b0110111);             // lui x3
        imem[3]  = enc_i(32'h678, 3, 3'b000, 3, 7'b0010011);    // addi x3,x3,0x678
        imem[4]  = enc_s(0, 3, 0, 3'b010);                      // sw x3,0(x0)
        imem[5]  = enc_i(1, 0, 3'b000, 4, 7'b0000011);          // lb x4,1(x0)
        imem[6]  = enc_i(3, 0, 3'b100, 5, 7'b0000011);          // lbu x5,3(x0)
        imem[7]  = enc_u(20'h0000C, 6, 7'b0110111);             // lui x6,0xC
        imem[8]  = enc_i(-273, 6, 3'b000, 6, 7'b0010011);       // x6 = 0xBEEF
        imem[9]  = enc_s(2, 6, 0, 3'b001);                      // sh x6,2(x0)
        imem[10] = enc_i(2, 0, 3'b001, 7, 7'b0000011);          // lh x7,2(x0)
        imem[11] = enc_i(1, 0, 3'b000, 0, 7'b0010011);          // addi x0,x0,1
        imem[12] = enc_u(20'h80000, 8, 7'b0110111);             // lui x8
        imem[13] = enc_i(4, 0, 3'b000, 10, 7'b0010011);         // addi x10,x0,4
        imem[14] = enc_r(7'b0100000, 10, 8, 3'b101, 9);         // sra x9,x8,x10
        imem[15] = enc_i(32'h404, 8, 3'b101, 11, 7'b0010011);   // srai x11,x8,4
        imem[16] = enc_i(1, 0, 3'b000, 12, 7'b0010011);         // addi x12,x0,1
        imem[17] = enc_i(-1, 0, 3'b000, 13, 7'b0010011);        // addi x13,x0,-1
        imem[18] = enc_r(7'b0000000, 13, 12, 3'b011, 14);       // sltu x14,x12,x13
        imem[19] = enc_r(7'b0000000, 12, 13, 3'b010, 15);       // slt x15,x13,x12
        imem[20] = enc_r(7'b0100000, 13, 12, 3'b000, 16);       // sub x16,x12,x13
        imem[21] = HALT;
        for (int i = 0; i < 21; i++) exp_pc_q.push_back(32'(i * 4));

        do_reset();
        chk("rst_wb", {31'd0, wb}, 32'd0);
        chk("rst_dbg_pc", dbg_pc, 32'd0);
        @(negedge clk);
        chk("e1_reg01", r[1], 32'd5);
        chk("e1_wb", {31'd0, wb}, 32'd1);
        @(negedge clk);
        chk("e2_reg02", r[2], 32'hFFFF_FFFE);
        wait_done(100);
        repeat (10) @(negedge clk);
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_wb", {31'd0, wb}, 32'd0);
        chk("halt_dbg_pc", dbg_pc, 32'h50);
        chk("halt_imemaddr", imemaddr, 32'h54);
        chk("reg03", r[3], 32'h1234_5678);
        chk("lb_reg04", r[4], 32'h0000_0056);
        chk("lbu_reg05", r[5], 32'h0000_0012);
        chk("sh_word0", dmem[0], 32'hBEEF_5678);
        chk("lh_reg07", r[7], 32'hFFFF_BEEF);
        chk("reg00", r[0], 32'd0);
        chk("sra_reg09", r[9], 32'hF800_0000);
        chk("srai_reg11", r[11], 32'hF800_0000);
        chk("sltu_reg14", r[14], 32'd1);
        chk("slt_reg15", r[15], 32'd1);
        chk("sub_reg16", r[16], 32'd2);
        chk("trace_left1", exp_pc_q.size(), 32'd0);
        chk("commits1", n_commit, 32'd21);

        // Program 2: branches, jumps, auipc, unknown opcode; reset while halted
        for (int i = 0; i < 64; i++) imem[i] = HALT;
        imem[0]  = enc_i(1, 2, 3'b000, 2, 7'b0010011);          // addi x2,x2,1
        imem[1]  = enc_i(2, 0, 3'b000, 3, 7'b0010011);          // addi x3,x0,2
        imem[2]  = enc_b(8, 3, 2, 3'b001);                      // bne x2,x3,+8
        imem[3]  = enc_i(1, 1, 3'b000, 0, 7'b1100111);          // jalr x0,1(x1)
        imem[4]  = enc_b(8, 0, 0, 3'b000);                      // beq x0,x0,+8
        imem[5]  = enc_i(99, 0, 3'b000, 4, 7'b0010011);         // addi x4 (skipped)
        imem[6]  = enc_j(-24, 1);                               // jal x1,-0x18
        imem[7]  = enc_u(20'h00001, 6, 7'b0010111);             // auipc x6,1
        imem[8]  = 32'hFFFF_FFFF;                               // unknown opcode
        imem[9]  = enc_i(7, 0, 3'b000, 5, 7'b0010011);          // addi x5,x0,7
        imem[10] = HALT;
        begin
            logic [31:0] tr [12];
            tr = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h18, 32'h00,
                   32'h04, 32'h08, 32'h0C, 32'h1C, 32'h20, 32'h24};
            foreach (tr[i]) exp_pc_q.push_back(tr[i]);
        end

        do_reset();
        n_commit = 0;
        chk("rst2_done", {31'd0, done}, 32'd0);
        chk("rst2_reg01", r[1], 32'd0);
        chk("rst2_dbg_pc", dbg_pc, 32'd0);
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("jal_reg01", r[1], 32'h1C);
        chk("loop_reg02", r[2], 32'd2);
        chk("skip_reg04", r[4], 32'd0);
        chk("addi_reg05", r[5], 32'd7);
        chk("auipc_reg06", r[6], 32'h101C);
        chk("nop_reg31", r[31], 32'd0);
        chk("halt2_dbg_pc", dbg_pc, 32'h24);
        chk("trace_left2", exp_pc_q.size(), 32'd0);
        chk("commits2", n_commit, 32'd12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
